// File: rtl/tx_ts_pkg.sv
// Shared definitions for the timestamp request arbiter: FSM state encoding,
// channel-index width helper and frame field placement.
package tx_ts_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ASM  = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } tx_state_t;

    // Channel index width, never narrower than one bit so a single channel still has a field.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Final value of the assembly counter; zero assembly cycles still spends one cycle.
    function automatic int asm_last(input int asm_cyc);
        return (asm_cyc <= 1) ? 0 : asm_cyc - 1;
    endfunction

    localparam int FRAME_DATA_LSB = 0;

    function automatic int frame_addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int frame_ch_lsb(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// otherwise the search wraps around to channel 0.
module rr_arb
    import tx_ts_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            any_req
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int j = 0; j < N_CH; j++) begin
            if (!any_req && (j >= int'(ptr)) && req[j]) begin
                any_req   = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = CH_W'(j);
            end
        end
        for (int j = 0; j < N_CH; j++) begin
            if (!any_req && (j < int'(ptr)) && req[j]) begin
                any_req   = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = CH_W'(j);
            end
        end
    end

endmodule

// File: rtl/tx_ts_arbiter.sv
// Arbitrates per-channel timestamp requests onto a single gPTP timestamp sender,
// waits for its response (or a timeout) and returns it to the granted channel.
module tx_ts_arbiter
    import tx_ts_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 80,
    parameter int TS_W    = 80,
    parameter int FRAME_W = 352,
    parameter int ASM_CYC = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          send_vaild,
    input  logic [N_CH*ADDR_W-1:0]   send_addr,
    input  logic [N_CH*DATA_W-1:0]   send_data,
    output logic [N_CH-1:0]          send_ready,
    output logic [N_CH-1:0]          send_r_vaild,
    output logic [TS_W-1:0]          send_r_data,
    output logic                     send_r_err,
    output logic                     gptp_ts_vaild,
    input  logic                     gptp_ts_ready,
    output logic [FRAME_W-1:0]       gptp_ts_data,
    input  logic                     gptp_ts_rv_vaild,
    input  logic [TS_W-1:0]          gptp_ts_rv_data,
    output logic                     busy,
    output logic [15:0]              drop_cnt
);

    localparam int          CH_W     = ch_width(N_CH);
    localparam int          ADDR_LSB = frame_addr_lsb(DATA_W);
    localparam int          CH_LSB   = frame_ch_lsb(ADDR_W, DATA_W);
    localparam logic [15:0] ASM_LAST = 16'(asm_last(ASM_CYC));
    localparam int          TO_W     = $clog2(TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    tx_state_t         state;
    logic [CH_W-1:0]   ptr;
    logic [N_CH-1:0]   cur_grant;
    logic [15:0]       asm_cnt;
    logic [TO_W-1:0]   to_cnt;

    logic [N_CH-1:0]   grant;
    logic [CH_W-1:0]   grant_idx;
    logic              any_req;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [FRAME_W-1:0] frame_next;

    rr_arb #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_arb (
        .req       (send_vaild),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // The frame is captured at grant time, so the requester's fields only matter up to then.
    always_comb begin
        sel_addr   = '0;
        sel_data   = '0;
        frame_next = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (grant[j]) begin
                sel_addr = send_addr[j*ADDR_W +: ADDR_W];
                sel_data = send_data[j*DATA_W +: DATA_W];
            end
        end
        frame_next[FRAME_DATA_LSB +: DATA_W] = sel_data;
        frame_next[ADDR_LSB +: ADDR_W]       = sel_addr;
        frame_next[CH_LSB +: CH_W]           = grant_idx;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            cur_grant     <= '0;
            asm_cnt       <= '0;
            to_cnt        <= '0;
            send_ready    <= '0;
            send_r_vaild  <= '0;
            send_r_data   <= '0;
            send_r_err    <= 1'b0;
            gptp_ts_vaild <= 1'b0;
            gptp_ts_data  <= '0;
            drop_cnt      <= '0;
        end else begin
            send_ready   <= '0;
            send_r_vaild <= '0;

            // Responses arriving outside WAIT have no owner and are only counted.
            if (gptp_ts_rv_vaild && (state != WAIT) && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;

            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        send_ready   <= grant;
                        cur_grant    <= grant;
                        gptp_ts_data <= frame_next;
                        ptr          <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
                        asm_cnt      <= '0;
                        state        <= ASM;
                    end
                end
                ASM: begin
                    if (asm_cnt == ASM_LAST) begin
                        gptp_ts_vaild <= 1'b1;
                        state         <= SEND;
                    end else begin
                        asm_cnt <= asm_cnt + 16'd1;
                    end
                end
                SEND: begin
                    if (gptp_ts_ready) begin
                        gptp_ts_vaild <= 1'b0;
                        to_cnt        <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // A response landing on the timeout cycle still counts as a response.
                    if (gptp_ts_rv_vaild) begin
                        send_r_data  <= gptp_ts_rv_data;
                        send_r_err   <= 1'b0;
                        send_r_vaild <= cur_grant;
                        state        <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        send_r_data  <= '0;
                        send_r_err   <= 1'b1;
                        send_r_vaild <= cur_grant;
                        state        <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
